adc_dig_corr: RTL and testbench
===============================

# adc_dig_corr

Parametrised digital-correction back end for a pipelined ADC. It takes per-stage redundant sub-codes from NSTAGE pipeline stages plus a backend flash code and time-aligns them with in_valid-gated delay lines. It then merges them into one OUT_W-bit sample, either by true overlap addition with saturation or by the legacy bitwise-OR merge. It sits between the stage comparator/encoder logic and the downstream sample FIFO, and runs in a single clock domain.

## Interface
- NSTAGE, 4, number of redundant pipeline stages (≥2)
- SBITS, 3, sub-code width per redundant stage (≥2; 1-bit overlap with next stage)
- BBITS, 4, backend flash code width (≥2)
- OUT_W, NSTAGE*(SBITS-1)+BBITS (derived, localparam), output sample width
- clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- stage_code  in  NSTAGE*SBITS  stage k code at bits [k*SBITS +: SBITS], stage 0 = first (MSB) stage
- back_code  in  BBITS  backend flash code
- in_valid  in  1  strobe: all code inputs valid this cycle
- corr_en  in  1  1 = overlap addition, 0 = legacy OR merge
- dout  out  OUT_W  corrected sample
- out_valid  out  1  one-cycle pulse, dout valid
- ovf  out  1  sum exceeded OUT_W bits this sample (dout saturated)

## Operation
- Data arrival: for sample n, stage k code arrives with strobe n+k; back_code arrives with strobe n+NSTAGE.
- Alignment: stage k has a delay line of depth NSTAGE-k registers (SBITS wide), shifting only on in_valid. back_code is not delayed.
- Merge weight: stage k shifted left by (NSTAGE-1-k)*(SBITS-1)+(BBITS-1); back_code weight 0.
- corr_en=1: unsigned sum in OUT_W+1 bits. If bit OUT_W is set, dout = all ones and ovf=1; otherwise dout = sum[OUT_W-1:0] and ovf=0.
- corr_en=0: overlapping bits are ORed, with no carries; ovf=0.
- Fill counter: 0..NSTAGE, increments on each in_valid and saturates at NSTAGE. out_valid is suppressed while the count is below NSTAGE at the strobe, so the first output corresponds to the (NSTAGE+1)th strobe after reset.
- dout and ovf hold their value between strobes.
- Reset (rst_n=0 at a clk edge): all delay lines, fill counter, dout, ovf and out_valid are cleared to 0.
  - Reset dominates a simultaneous in_valid.
  - A mid-stream reset discards all in-flight samples, and fill restarts from 0.
- corr_en is sampled on the same edge that registers dout, so a change applies to the next produced sample only.
- in_valid may be asserted every cycle, or with arbitrary gaps. Gaps stall alignment without data loss.

## Timing
- Latency: dout/out_valid/ovf update on the clk edge at which strobe n+NSTAGE is sampled. They are visible the cycle after that strobe; one register stage in total.
- Throughput: one sample per clk.
- out_valid is high exactly one cycle per qualifying strobe, and never high without a strobe on the preceding edge.
- Reset values: dout=0, out_valid=0, ovf=0.
- Merge path is combinational from the delay-line outputs and back_code into the output register; no other pipelining.

## Test plan
All cases use defaults (NSTAGE=4, SBITS=3, BBITS=4, OUT_W=12).
- Reset/fill: rst_n=0 for 2 cycles, then 4 strobes -> out_valid stays 0, dout=0. The 5th strobe -> out_valid=1 the next cycle.
- Neutral codes, corr_en=1: every strobe carries all stage codes 3'b010 and back_code 4'b0100 -> dout=0x554, ovf=0.
- Carry propagation: all stage codes 3'b011, back_code 4'b1000.
  - corr_en=1 -> dout=0x800.
  - corr_en=0 -> dout=0x7F8.
- Saturation: all stage codes 3'b111, back_code 4'b1111, corr_en=1 -> sum 4775, dout=0xFFF, ovf=1. The next sample at neutral codes -> ovf=0.
- Alignment with gaps:
  - Stimulus: distinct per-sample codes on strobes spaced by random 0–3 idle cycles.
  - Required: each dout equals the reference sum of sample n's stage codes (strobes n..n+3) and back_code (strobe n+4).
  - Required: out_valid count equals strobes minus 4.
- Mid-stream reset: rst_n=0 for 1 cycle coincident with in_valid after 10 samples -> next cycle dout=0, out_valid=0, ovf=0. The next 4 strobes give no output, and the 5th produces a valid sample.

Source files
------------

// File: rtl/adc_dig_corr.sv
// -----------------------------------------------------------------------------
// adc_dig_corr
//
// Digital-correction back end for a pipelined ADC. Each redundant stage sends
// an SBITS-wide sub-code that overlaps the next stage by one bit. A BBITS-wide
// backend flash code finishes the conversion. Sample n reaches this block
// spread over NSTAGE+1 strobes: stage k on strobe n+k, and the backend code on
// strobe n+NSTAGE. Per-stage delay lines bring every piece of sample n into
// line. The pieces are then merged into one OUT_W-bit word, either by true
// overlap addition with saturation or by the legacy bitwise-OR merge.
//
// Strobe semantics: in_valid is a one-cycle qualifier with no back-pressure.
// Every cycle with in_valid=1 presents one complete set of codes, and every
// register in the block advances only on such a cycle. out_valid is a
// one-cycle pulse that follows a qualifying strobe. dout/ovf hold otherwise.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : synchronous active-low reset
//   stage_code : NSTAGE*SBITS, stage k at [k*SBITS +: SBITS], stage 0 = MSB stage
//   back_code  : BBITS backend flash code
//   in_valid   : all code inputs valid this cycle
//   corr_en    : 1 = overlap addition, 0 = legacy OR merge
//   dout       : OUT_W corrected sample (registered)
//   out_valid  : one-cycle pulse, dout valid
//   ovf        : overlap sum exceeded OUT_W bits, dout saturated
// -----------------------------------------------------------------------------
module adc_dig_corr #(
   parameter  int NSTAGE = 4,
   parameter  int SBITS  = 3,
   parameter  int BBITS  = 4,
   localparam int OUT_W  = NSTAGE*(SBITS-1)+BBITS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NSTAGE*SBITS-1:0] stage_code,
   input  logic [BBITS-1:0]        back_code,
   input  logic                    in_valid,
   input  logic                    corr_en,
   output logic [OUT_W-1:0]        dout,
   output logic                    out_valid,
   output logic                    ovf
);

   localparam int SUMW = OUT_W + 1;
   localparam int FW   = $clog2(NSTAGE + 1);

   logic [SBITS-1:0] w_tail [NSTAGE];
   logic [SUMW-1:0]  w_sum;
   logic [OUT_W-1:0] w_or;
   logic [OUT_W-1:0] w_merge;
   logic             w_ovf;

   logic [FW-1:0]    r_fill;
   logic [OUT_W-1:0] r_dout;
   logic             r_out_valid;
   logic             r_ovf;

   // Stage k needs NSTAGE-k strobes of delay so that its code for sample n
   // sits at the tail exactly when the backend code for sample n arrives.
   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      localparam int DEPTH = NSTAGE - k;
      logic [SBITS-1:0] r_line [DEPTH];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
         end else if (in_valid) begin
            r_line[0] <= stage_code[k*SBITS +: SBITS];
            for (int i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
         end
      end

      assign w_tail[k] = r_line[DEPTH-1];
   end

   // Merge: stage k weight is (NSTAGE-1-k)*(SBITS-1)+(BBITS-1). The backend
   // code has weight 0. The sum carries one extra bit so that an overflow of
   // the OUT_W range can be seen and saturated.
   always_comb begin
      w_sum = SUMW'(back_code);
      w_or  = OUT_W'(back_code);
      for (int k = 0; k < NSTAGE; k++) begin
         w_sum = w_sum + (SUMW'(w_tail[k]) << ((NSTAGE-1-k)*(SBITS-1)+(BBITS-1)));
         w_or  = w_or  | (OUT_W'(w_tail[k]) << ((NSTAGE-1-k)*(SBITS-1)+(BBITS-1)));
      end
      w_ovf   = corr_en & w_sum[OUT_W];
      if (!corr_en)          w_merge = w_or;
      else if (w_sum[OUT_W]) w_merge = '1;
      else                   w_merge = w_sum[OUT_W-1:0];
   end

   // The fill count saturates at NSTAGE. A strobe produces output only once
   // every delay line already holds real data at that strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fill      <= '0;
         r_dout      <= '0;
         r_out_valid <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (in_valid) begin
            if (r_fill != FW'(NSTAGE)) r_fill <= r_fill + 1'b1;
            if (r_fill == FW'(NSTAGE)) begin
               r_out_valid <= 1'b1;
               r_dout      <= w_merge;
               r_ovf       <= w_ovf;
            end
         end
      end
   end

   assign dout      = r_dout;
   assign out_valid = r_out_valid;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_adc_dig_corr.sv
// -----------------------------------------------------------------------------
// tb_adc_dig_corr
//
// Bench for adc_dig_corr at its default parameters (4 stages, 3-bit sub-codes,
// 4-bit backend, 12-bit output). It runs these phases:
//   - reset and fill
//   - a table of constant-code vectors
//   - a gapped alignment run checked by a scoreboard queue
//   - a mid-stream reset
// -----------------------------------------------------------------------------
module tb_adc_dig_corr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] stage_code = '0;
  logic [3:0]  back_code = '0;
  logic        in_valid = 1'b0;
  logic        corr_en = 1'b1;
  logic [11:0] dout;
  logic        out_valid;
  logic        ovf;

  adc_dig_corr dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stage_code (stage_code),
    .back_code  (back_code),
    .in_valid   (in_valid),
    .corr_en    (corr_en),
    .dout       (dout),
    .out_valid  (out_valid),
    .ovf        (ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1);
  end

  // ---------------- counters / checker ----------------
  int n_pass = 0;
  int n_total = 0;
  int n_vout = 0;
  logic mon_en = 1'b0;
  logic [12:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: {ovf, dout} for one sample, with explicit weights.
  function automatic logic [12:0] ref_out(input logic [2:0] s0, input logic [2:0] s1,
                                          input logic [2:0] s2, input logic [2:0] s3,
                                          input logic [3:0] b, input logic ce);
    int sum;
    logic [11:0] o;
    sum = int'(s0)*512 + int'(s1)*128 + int'(s2)*32 + int'(s3)*8 + int'(b);
    if (ce) begin
      if (sum > 4095) return {1'b1, 12'hFFF};
      return {1'b0, 12'(sum)};
    end
    o = {s0, 9'b0} | {2'b0, s1, 7'b0} | {4'b0, s2, 5'b0} | {6'b0, s3, 3'b0} | {8'b0, b};
    return {1'b0, o};
  endfunction

  function automatic logic [11:0] pack(input logic [2:0] s0, input logic [2:0] s1,
                                       input logic [2:0] s2, input logic [2:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid) begin
      logic [12:0] e;
      n_vout++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_dout", dout, e[11:0]);
        chk("sb_ovf", ovf, e[12]);
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic strobe(input logic [11:0] sc, input logic [3:0] bc, input logic ce);
    stage_code = sc;
    back_code  = bc;
    corr_en    = ce;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [11:0] sc;
    logic [3:0]  bc;
    logic        ce;
    logic [11:0] exp_d;
    logic        exp_o;
  } vec_t;

  vec_t vecs[7];
  logic [2:0] smp_s[32][4];
  logic [3:0] smp_b[32];
  logic [11:0] neutral;

  initial begin
    neutral = pack(3'b010, 3'b010, 3'b010, 3'b010);
    vecs[0] = '{neutral,                                   4'b0100, 1'b1, 12'h554, 1'b0};
    vecs[1] = '{pack(3'b011, 3'b011, 3'b011, 3'b011),      4'b1000, 1'b1, 12'h800, 1'b0};
    vecs[2] = '{pack(3'b011, 3'b011, 3'b011, 3'b011),      4'b1000, 1'b0, 12'h7F8, 1'b0};
    vecs[3] = '{pack(3'b111, 3'b111, 3'b111, 3'b111),      4'b1111, 1'b1, 12'hFFF, 1'b1};
    vecs[4] = '{neutral,                                   4'b0100, 1'b1, 12'h554, 1'b0};
    vecs[5] = '{pack(3'b111, 3'b111, 3'b111, 3'b111),      4'b1111, 1'b0, 12'hFFF, 1'b0};
    vecs[6] = '{pack(3'd1, 3'd2, 3'd3, 3'd4),              4'd5,    1'b1, 12'h385, 1'b0};

    // ---- reset / fill ----
    idle(2);
    chk("rst_dout", dout, 12'h000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      strobe(neutral, 4'b0100, 1'b1);
      chk($sformatf("fill_valid_%0d", i), out_valid, 1'b0);
      chk($sformatf("fill_dout_%0d", i), dout, 12'h000);
    end
    strobe(neutral, 4'b0100, 1'b1);
    chk("fill_5th_valid", out_valid, 1'b1);
    chk("fill_5th_dout", dout, 12'h554);
    idle(1);
    chk("fill_pulse_low", out_valid, 1'b0);

    // ---- table: five identical strobes flush the pipeline ----
    for (int v = 0; v < 7; v++) begin
      for (int s = 0; s < 5; s++) strobe(vecs[v].sc, vecs[v].bc, vecs[v].ce);
      chk($sformatf("vec%0d_valid", v), out_valid, 1'b1);
      chk($sformatf("vec%0d_dout", v), dout, vecs[v].exp_d);
      chk($sformatf("vec%0d_ovf", v), ovf, vecs[v].exp_o);
      idle(2);
      chk($sformatf("vec%0d_hold_dout", v), dout, vecs[v].exp_d);
      chk($sformatf("vec%0d_hold_valid", v), out_valid, 1'b0);
    end

    // ---- alignment with random gaps, random merge mode ----
    @(negedge clk);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    for (int m = 0; m < 32; m++) begin
      for (int k = 0; k < 4; k++) smp_s[m][k] = 3'($urandom_range(0, 7));
      smp_b[m] = 4'($urandom_range(0, 15));
    end
    n_vout = 0;
    mon_en = 1'b1;
    for (int j = 0; j < 24; j++) begin
      logic [11:0] sc;
      logic [3:0]  bc;
      logic        ce;
      sc = '0;
      for (int k = 0; k < 4; k++)
        sc[k*3 +: 3] = (j >= k) ? smp_s[j-k][k] : 3'($urandom_range(0, 7));
      bc = (j >= 4) ? smp_b[j-4] : 4'($urandom_range(0, 15));
      ce = 1'($urandom_range(0, 1));
      if (j >= 4)
        exp_q.push_back(ref_out(smp_s[j-4][0], smp_s[j-4][1], smp_s[j-4][2],
                                smp_s[j-4][3], smp_b[j-4], ce));
      strobe(sc, bc, ce);
      idle($urandom_range(0, 3));
    end
    idle(3);
    mon_en = 1'b0;
    chk("align_valid_count", n_vout, 32'd20);
    chk("align_queue_empty", exp_q.size(), 32'd0);

    // ---- mid-stream reset coincident with a strobe ----
    for (int i = 0; i < 10; i++) strobe(neutral, 4'b0100, 1'b1);
    chk("mid_pre_dout", dout, 12'h554);
    stage_code = pack(3'b111, 3'b111, 3'b111, 3'b111);
    back_code  = 4'b1111;
    corr_en    = 1'b1;
    in_valid   = 1'b1;
    rst_n      = 1'b0;
    @(negedge clk);
    in_valid   = 1'b0;
    rst_n      = 1'b1;
    chk("mid_rst_dout", dout, 12'h000);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ovf", ovf, 1'b0);
    for (int i = 0; i < 4; i++) begin
      strobe(neutral, 4'b0100, 1'b1);
      chk($sformatf("mid_refill_valid_%0d", i), out_valid, 1'b0);
    end
    strobe(neutral, 4'b0100, 1'b1);
    chk("mid_5th_valid", out_valid, 1'b1);
    chk("mid_5th_dout", dout, 12'h554);
    chk("mid_5th_ovf", ovf, 1'b0);

    // ---- report ----
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
